// File: rtl/mist32e_memory_responder.sv
// rtl/mist32e_memory_responder.sv - 64-bit RAM responder with pipelined reads and response FIFO
module mist32e_memory_responder #(
  parameter int P_DEPTH_LOG2 = 10,
  parameter int P_RESP_DEPTH = 4
) (
  input  logic        iCLOCK,
  input  logic        iRESET_SYNC,
  input  logic        iMEMORY_REQ,
  output logic        oMEMORY_BUSY,
  input  logic [3:0]  iMEMORY_MASK,
  input  logic        iMEMORY_RW,
  input  logic [31:0] iMEMORY_ADDR,
  input  logic [31:0] iMEMORY_DATA,
  output logic        oMEMORY_VALID,
  input  logic        iMEMORY_BUSY,
  output logic [63:0] oMEMORY_DATA
);

  localparam int LP_ENTRIES = 1 << P_DEPTH_LOG2;
  localparam int LP_PTR_W   = $clog2(P_RESP_DEPTH);
  localparam int LP_OCC_W   = LP_PTR_W + 1;

  logic [63:0]             r_ram [LP_ENTRIES];

  // pending write (commits on the edge after acceptance)
  logic                    r_wr_valid;
  logic [P_DEPTH_LOG2-1:0] r_wr_idx;
  logic                    r_wr_upper;
  logic [3:0]              r_wr_mask;
  logic [31:0]             r_wr_data;

  // read stage A: captured request; stage B: RAM data
  logic                    r_a_valid;
  logic [P_DEPTH_LOG2-1:0] r_a_idx;
  logic                    r_a_oor;
  logic                    r_b_valid;
  logic [63:0]             r_b_data;

  // response FIFO
  logic [63:0]             r_fifo [P_RESP_DEPTH];
  logic [LP_PTR_W-1:0]     r_wptr;
  logic [LP_PTR_W-1:0]     r_rptr;
  logic [LP_OCC_W-1:0]     r_cnt;
  logic [LP_OCC_W-1:0]     r_occ;

  logic                    w_accept;
  logic                    w_in_range;
  logic [P_DEPTH_LOG2-1:0] w_idx;
  logic                    w_acc_rd;
  logic                    w_acc_wr;
  logic                    w_pop;

  assign w_in_range    = (iMEMORY_ADDR[31:P_DEPTH_LOG2+1] == '0);
  assign w_idx         = iMEMORY_ADDR[P_DEPTH_LOG2:1];
  assign oMEMORY_BUSY  = (r_occ == LP_OCC_W'(P_RESP_DEPTH)) | iRESET_SYNC;
  assign w_accept      = iMEMORY_REQ & ~oMEMORY_BUSY;
  assign w_acc_rd      = w_accept & ~iMEMORY_RW;
  // out-of-range and empty-mask writes are accepted but leave the RAM alone
  assign w_acc_wr      = w_accept & iMEMORY_RW & w_in_range & (iMEMORY_MASK != 4'h0);
  assign oMEMORY_VALID = (r_cnt != '0) & ~iRESET_SYNC;
  assign oMEMORY_DATA  = oMEMORY_VALID ? r_fifo[r_rptr] : 64'h0;
  assign w_pop         = oMEMORY_VALID & ~iMEMORY_BUSY;

  // RAM array: byte-masked half-entry writes and the single registered read stage; never reset
  always_ff @(posedge iCLOCK) begin
    if (r_wr_valid && !iRESET_SYNC) begin
      for (int i = 0; i < 4; i++) begin
        if (r_wr_mask[i]) begin
          if (r_wr_upper) r_ram[r_wr_idx][32+8*i +: 8] <= r_wr_data[8*i +: 8];
          else            r_ram[r_wr_idx][8*i +: 8]    <= r_wr_data[8*i +: 8];
        end
      end
    end
    // a write accepted just before this read has already committed one edge earlier
    r_b_data <= r_a_oor ? 64'h0 : r_ram[r_a_idx];
  end

  // request capture, read pipeline valids, occupancy and FIFO bookkeeping
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      r_wr_valid <= 1'b0;
      r_a_valid  <= 1'b0;
      r_b_valid  <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_cnt      <= '0;
      r_occ      <= '0;
    end else begin
      r_wr_valid <= w_acc_wr;
      r_wr_idx   <= w_idx;
      r_wr_upper <= ~iMEMORY_ADDR[0];
      r_wr_mask  <= iMEMORY_MASK;
      r_wr_data  <= iMEMORY_DATA;

      r_a_valid  <= w_acc_rd;
      r_a_idx    <= w_idx;
      r_a_oor    <= ~w_in_range;
      r_b_valid  <= r_a_valid;

      if (r_b_valid) begin
        r_fifo[r_wptr] <= r_b_data;
        r_wptr         <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;

      case ({r_b_valid, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase

      // occupancy covers both pipeline stages, so the FIFO can never overflow
      case ({w_acc_rd, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: doc/mist32e_memory_responder.md
MIST32E_MEMORY_RESPONDER -- requirements
Module: mist32e_memory_responder

Interface
REQ-001 The block SHALL have parameter P_DEPTH_LOG2, default 10, meaning log2 of the number of 64-bit RAM entries.
REQ-002 The block SHALL have parameter P_RESP_DEPTH, default 4, meaning the number of read responses that may be outstanding (power of 2, min 2).
REQ-003 The block SHALL have port iCLOCK  in  1  meaning the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port iRESET_SYNC  in  1  meaning the reset; reset is synchronous and active-high.
REQ-005 The block SHALL have port iMEMORY_REQ  in  1  meaning the master presents a request.
REQ-006 The block SHALL have port oMEMORY_BUSY  out  1  meaning the responder cannot accept a request this cycle.
REQ-007 The block SHALL have port iMEMORY_MASK  in  4  meaning write byte enables; bit i enables iMEMORY_DATA[8i+7:8i].
REQ-008 The block SHALL have port iMEMORY_RW  in  1  meaning 1 for write and 0 for read.
REQ-009 The block SHALL have port iMEMORY_ADDR  in  32  meaning the 32-bit word address.
REQ-010 The block SHALL have port iMEMORY_DATA  in  32  meaning the write data.
REQ-011 The block SHALL have port oMEMORY_VALID  out  1  meaning read response data is valid.
REQ-012 The block SHALL have port iMEMORY_BUSY  in  1  meaning the master cannot take a response this cycle.
REQ-013 The block SHALL have port oMEMORY_DATA  out  64  meaning the read response, one full 64-bit RAM entry.

Function
REQ-014 A request SHALL be accepted on a rising edge where iMEMORY_REQ=1 and oMEMORY_BUSY=0; no request is taken otherwise.
REQ-015 The RAM entry index SHALL be iMEMORY_ADDR[P_DEPTH_LOG2:1]; iMEMORY_ADDR[0]=0 selects the upper half [63:32] and iMEMORY_ADDR[0]=1 selects the lower half [31:0].
REQ-016 An address SHALL be in range iff iMEMORY_ADDR[31:P_DEPTH_LOG2+1]==0.
REQ-017 An accepted write SHALL update only the masked bytes of the selected half, and SHALL commit on the edge after acceptance.
REQ-018 A write SHALL produce no response.
REQ-019 An out-of-range write SHALL be dropped.
REQ-020 A write with mask 4'h0 SHALL be accepted with no RAM change.
REQ-021 For an accepted read, the read SHALL return the whole 64-bit entry.
REQ-022 An out-of-range read SHALL return 64'h0 and still produce exactly one response.
REQ-023 Requests SHALL take effect in acceptance order, and a read SHALL observe every earlier-accepted write, including a write accepted on the immediately preceding edge (forwarding or stall required).
REQ-024 Read data SHALL pass through a one-stage RAM read, then into a response FIFO of P_RESP_DEPTH entries.
REQ-025 oMEMORY_VALID/oMEMORY_DATA SHALL present the FIFO head.
REQ-026 Read latency SHALL be: a read accepted at edge k with an empty FIFO and iMEMORY_BUSY=0 shows oMEMORY_VALID=1 after edge k+2.
REQ-027 A response SHALL be consumed (popped) at an edge where oMEMORY_VALID=1 and iMEMORY_BUSY=0.
REQ-028 While iMEMORY_BUSY=1, oMEMORY_VALID and oMEMORY_DATA SHALL hold stable.
REQ-029 The responder SHALL track occupancy = reads in the RAM stage + FIFO entries.
REQ-030 oMEMORY_BUSY SHALL equal (occupancy == P_RESP_DEPTH) OR iRESET_SYNC, and SHALL be derived only from registered state and iRESET_SYNC.
REQ-031 Writes SHALL also be refused while oMEMORY_BUSY=1, keeping ordering simple.
REQ-032 On a simultaneous accept-read and pop, occupancy SHALL be unchanged.
REQ-033 The FIFO SHALL never overflow or underflow.
REQ-034 Responses SHALL be returned in acceptance order.

Reset
REQ-035 While iRESET_SYNC=1 the block SHALL assert oMEMORY_BUSY=1 and oMEMORY_VALID=0, and drive oMEMORY_DATA=64'h0.
REQ-036 At the reset edge, occupancy, FIFO pointers and pending write/read stages SHALL clear.
REQ-037 A reset asserted mid-operation SHALL discard all in-flight reads and any uncommitted write.
REQ-038 RAM contents SHALL NOT be reset, and SHALL be preserved across reset.
REQ-039 The first request SHALL be acceptable on the first edge after iRESET_SYNC deasserts.

Verification
REQ-040 The bench SHALL cover write addr 0x2 data 0xDEADBEEF mask 4'hF, write addr 0x3 data 0x01234567 mask 4'hF, read addr 0x2 -> exactly one response 0xDEADBEEF_01234567 two edges after acceptance.
REQ-041 The bench SHALL cover write addr 0x2 data 0xAABBCCDD mask 4'b0101 over the previous contents, read addr 0x3 -> 0xDEBBBEDD_01234567.
REQ-042 The bench SHALL cover a back-to-back write addr 0x4 data 0x11111111 then read addr 0x4 on consecutive accepted edges -> upper half of the response = 0x11111111.
REQ-043 The bench SHALL cover iMEMORY_BUSY=1 with 6 reads requested -> 4 accepted, oMEMORY_BUSY=1; on releasing iMEMORY_BUSY -> 6 in-order responses, each held stable while stalled.
REQ-044 The bench SHALL cover read of addr 0x0000_1000 with P_DEPTH_LOG2=10 -> response 64'h0.
REQ-045 The bench SHALL cover a write addr 0x0000_1000 -> no RAM entry changes.
REQ-046 The bench SHALL cover 2 reads outstanding, then iRESET_SYNC pulsed for 1 cycle -> no responses emitted, oMEMORY_BUSY=1 during reset, earlier-written RAM data intact on a later read.
